// File: rtl/gpio_serial_writer.sv
// gpio_serial_writer: LSB-first serial loader driving dac_driver shift clocks.
// Define GPIO_SERIAL_WRITER_ABORT_EN to add the abort_in port.
module gpio_serial_writer #(
  parameter int DATA_WIDTH   = 256,
  parameter int NUM_TARGETS  = 6,
  parameter int SETUP_CYCLES = 2,
  parameter int HIGH_CYCLES  = 2,
  parameter int HOLD_CYCLES  = 2,
  parameter int TW = $clog2(NUM_TARGETS),
  parameter int LW = $clog2(DATA_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [TW-1:0]          cmd_target,
  input  logic [DATA_WIDTH-1:0]  cmd_data,
  input  logic [LW-1:0]          cmd_len,
  output logic                   sdata,
  output logic [NUM_TARGETS-1:0] sclk,
  output logic                   select_out,
  output logic                   busy,
  output logic                   done,
  output logic                   err
`ifdef GPIO_SERIAL_WRITER_ABORT_EN
  ,
  input  logic                   abort_in
`endif
);

  localparam int MAX_SH = (SETUP_CYCLES > HIGH_CYCLES) ?
                          SETUP_CYCLES : HIGH_CYCLES;
  localparam int MAXC = (MAX_SH > HOLD_CYCLES) ? MAX_SH : HOLD_CYCLES;
  localparam int PW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int SU1  = SETUP_CYCLES - 1;
  localparam int HI1  = HIGH_CYCLES - 1;
  localparam int HO1  = HOLD_CYCLES - 1;

  localparam logic [PW-1:0] SU_L = SU1[PW-1:0];
  localparam logic [PW-1:0] HI_L = HI1[PW-1:0];
  localparam logic [PW-1:0] HO_L = HO1[PW-1:0];
  localparam logic [TW:0]   NT   = NUM_TARGETS[TW:0];
  localparam logic [LW:0]   DW   = DATA_WIDTH[LW:0];
  localparam logic [LW-1:0] ONE  = {{(LW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_SETUP,
    S_HIGH,
    S_HOLD,
    S_FINISH
  } state_t;

  state_t                  state_q;
  logic [PW-1:0]           phase_q;
  logic [LW-1:0]           bits_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic [TW-1:0]           tgt_q;
  logic                    sdata_q;
  logic                    sel_q;
  logic                    done_q;
  logic                    err_q;
  logic [NUM_TARGETS-1:0]  sclk_q;

  logic [PW-1:0]           phase_d;
  logic [LW-1:0]           bits_d;
  logic [DATA_WIDTH-1:0]   shreg_d;
  logic [NUM_TARGETS-1:0]  sclk_d;
  logic                    bad_cmd;
  logic                    abort;
  logic                    in_xfer;

`ifdef GPIO_SERIAL_WRITER_ABORT_EN
  assign abort = abort_in;
`else
  assign abort = 1'b0;
`endif

  assign phase_d = phase_q + 1'b1;
  assign bits_d  = bits_q - 1'b1;
  assign shreg_d = shreg_q >> 1;
  assign sclk_d  = {{(NUM_TARGETS-1){1'b0}}, 1'b1} << tgt_q;
  assign bad_cmd = ({1'b0, cmd_target} >= NT) ||
                   ({1'b0, cmd_len} > DW);
  assign in_xfer = state_q inside {S_SEL, S_SETUP, S_HIGH, S_HOLD};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      bits_q  <= '0;
      shreg_q <= '0;
      tgt_q   <= '0;
      sdata_q <= 1'b0;
      sclk_q  <= '0;
      sel_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort && in_xfer) begin
        state_q <= S_IDLE;
        phase_q <= '0;
        bits_q  <= '0;
        sclk_q  <= '0;
        sel_q   <= 1'b0;
        done_q  <= 1'b1;
        err_q   <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (cmd_valid) begin
              if (bad_cmd) begin
                err_q <= 1'b1;
              end else if (cmd_len == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q <= S_SEL;
                shreg_q <= cmd_data;
                tgt_q   <= cmd_target;
                bits_q  <= cmd_len;
                sdata_q <= cmd_data[0];
                sel_q   <= 1'b1;
                phase_q <= '0;
              end
            end
          end
          S_SEL: begin
            state_q <= S_SETUP;
            phase_q <= '0;
          end
          S_SETUP: begin
            if (phase_q == SU_L) begin
              state_q <= S_HIGH;
              phase_q <= '0;
              sclk_q  <= sclk_d;
            end else begin
              phase_q <= phase_d;
            end
          end
          S_HIGH: begin
            if (phase_q == HI_L) begin
              state_q <= S_HOLD;
              phase_q <= '0;
              sclk_q  <= '0;
            end else begin
              phase_q <= phase_d;
            end
          end
          S_HOLD: begin
            if (phase_q == HO_L) begin
              phase_q <= '0;
              // Count of 1 means the bit just clocked was the last one.
              if (bits_q == ONE) begin
                state_q <= S_FINISH;
                sel_q   <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_SETUP;
                bits_q  <= bits_d;
                shreg_q <= shreg_d;
                sdata_q <= shreg_q[1];
              end
            end else begin
              phase_q <= phase_d;
            end
          end
          S_FINISH: state_q <= S_IDLE;
          default:  state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign sdata      = sdata_q;
  assign sclk       = sclk_q;
  assign select_out = sel_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_gpio_serial_writer.sv
// tb_gpio_serial_writer: timeline model plus directed checks.
// Exercises abort_in when GPIO_SERIAL_WRITER_ABORT_EN is defined.
module tb_gpio_serial_writer;

  localparam int SU = 2;
  localparam int HI = 2;
  localparam int HO = 2;
  localparam int P  = SU + HI + HO;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_target = '0;
  logic [255:0] cmd_data = '0;
  logic [8:0]   cmd_len = '0;
  logic         sdata;
  logic [5:0]   sclk;
  logic         select_out;
  logic         busy;
  logic         done;
  logic         err;
  logic         abort_in = 1'b0;

  gpio_serial_writer dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_data   (cmd_data),
    .cmd_len    (cmd_len),
    .sdata      (sdata),
    .sclk       (sclk),
    .select_out (select_out),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef GPIO_SERIAL_WRITER_ABORT_EN
    ,
    .abort_in   (abort_in)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: t counts cycles since the accept edge (t=0 is the select cycle).
  bit           m_act = 1'b0;
  int           m_t = 0;
  int           m_len = 0;
  int           m_tgt = 0;
  logic [255:0] m_data = '0;
  int           m_pls = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_act = 1'b0;
      m_pls = 0;
    end else if (m_act) begin
      if (abort_in && m_t <= P * m_len) begin
        m_act = 1'b0;
        m_pls = 3;
      end else if (m_t == 1 + P * m_len) begin
        m_act = 1'b0;
      end else begin
        m_t++;
      end
    end else begin
      m_pls = 0;
      if (cmd_valid) begin
        if (int'(cmd_target) >= 6 || int'(cmd_len) > 256) m_pls = 1;
        else if (cmd_len == 0) m_pls = 2;
        else begin
          m_act  = 1'b1;
          m_t    = 0;
          m_len  = int'(cmd_len);
          m_tgt  = int'(cmd_target);
          m_data = cmd_data;
        end
      end
    end
  end

  int   rise [6];
  logic cap [$];
  logic [5:0] prev_sclk = '0;
  int   win_cnt = 0;
  int   low_cnt = 0;
  int   last_win = 0;
  int   last_gap = 0;
  logic prev_sel = 1'b0;

  initial forever begin
    logic [5:0]  es;
    logic [10:0] ev;
    logic        esel, ed, ee;
    int          ph, bi;
    @(negedge clk);
    if (chk_en) begin
      if (m_act) begin
        esel = (m_t <= P * m_len);
        ed   = (m_t == 1 + P * m_len);
        es   = '0;
        if (m_t >= 1 && m_t <= P * m_len) begin
          ph = (m_t - 1) % P;
          if (ph >= SU && ph < SU + HI) es[m_tgt] = 1'b1;
        end
        bi = (m_t == 0) ? 0 : (m_t - 1) / P;
        if (bi > m_len - 1) bi = m_len - 1;
        chk("sdata", {31'b0, sdata}, {31'b0, m_data[bi]});
        ev = {1'b0, 1'b1, esel, ed, 1'b0, es};
      end else begin
        ed = (m_pls == 2 || m_pls == 3);
        ee = (m_pls == 1 || m_pls == 3);
        ev = {1'b1, 1'b0, 1'b0, ed, ee, 6'b0};
      end
      chk("outs", {21'b0, cmd_ready, busy, select_out, done, err, sclk},
          {21'b0, ev});
      for (int b = 0; b < 6; b++) begin
        if (sclk[b] && !prev_sclk[b]) begin
          rise[b]++;
          cap.push_back(sdata);
        end
      end
      if (select_out) win_cnt++;
      else low_cnt++;
      if (prev_sel && !select_out) begin
        last_win = win_cnt;
        win_cnt  = 0;
      end
      if (!prev_sel && select_out) begin
        last_gap = low_cnt;
        low_cnt  = 0;
      end
    end
    prev_sclk = sclk;
    prev_sel  = select_out;
  end

  task automatic clr();
    @(posedge clk);
    for (int b = 0; b < 6; b++) rise[b] = 0;
    cap.delete();
  endtask

  task automatic send(input int tg, input int ln, input logic [255:0] d);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_target = tg[2:0];
    cmd_len    = ln[8:0];
    cmd_data   = d;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy !== 1'b0 || m_act) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", {31'b0, (k < 3000)}, 32'd1);
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, k;
    logic [255:0] d1;
    logic e;
    d1 = {{8{16'h0000}}, {8{16'hFFFF}}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_sdata", {31'b0, sdata}, 32'd0);
    chk("rst_sclk", {26'b0, sclk}, 32'd0);
    chk("rst_sel", {31'b0, select_out}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done_err", {30'b0, done, err}, 32'd0);
    rst = 1'b0;

    clr();
    send(2, 256, d1);
    wait_done(n);
    chk("t1_done_lat", n, 32'd1537);
    wait_idle();
    chk("t1_rises", rise[2], 32'd256);
    chk("t1_other", rise[0] + rise[1] + rise[3] + rise[4] + rise[5], 32'd0);
    chk("t1_win", last_win, 32'd1537);
    bad = 0;
    for (int i = 0; i < cap.size(); i++) if (cap[i] !== (i < 128)) bad++;
    chk("t1_bits", bad, 32'd0);

    clr();
    send(0, 8, 256'hFF);
    wait_done(n);
    chk("t2_done_lat", n, 32'd49);
    wait_idle();
    chk("t2_rises", rise[0], 32'd8);
    chk("t2_win", last_win, 32'd49);
    bad = 0;
    for (int i = 0; i < cap.size(); i++) if (cap[i] !== 1'b1) bad++;
    chk("t2_bits", bad, 32'd0);
    chk("t2_busy", {31'b0, busy}, 32'd0);

    clr();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_target = 3'd1; cmd_len = 9'd256; cmd_data = 256'd5;
    @(negedge clk);
    cmd_target = 3'd4; cmd_len = 9'd8; cmd_data = 256'd2;
    wait_done(n);
    chk("t3_first_lat", n, 32'd1537);
    @(negedge clk);
    chk("t3_idle_ready", {30'b0, cmd_ready, busy}, 32'd2);
    @(negedge clk);
    chk("t3_second_sel", {30'b0, busy, select_out}, 32'd3);
    cmd_valid = 1'b0;
    wait_done(n);
    chk("t3_second_lat", n, 32'd49);
    wait_idle();
    chk("t3_gap", last_gap, 32'd2);
    chk("t3_rises", {rise[1][15:0], rise[4][15:0]}, {16'd256, 16'd8});
    bad = 0;
    for (int i = 0; i < cap.size(); i++) begin
      e = (i < 256) ? (i == 0 || i == 2) : (i == 257);
      if (cap[i] !== e) bad++;
    end
    chk("t3_bits", bad + (cap.size() != 264), 32'd0);

    clr();
    send(6, 8, '1);
    chk("rej6_err", {29'b0, err, done, select_out}, 32'd4);
    chk("rej6_sclk", {26'b0, sclk}, 32'd0);
    @(negedge clk);
    chk("rej6_clear", {31'b0, err}, 32'd0);
    send(7, 4, '1);
    chk("rej7_err", {31'b0, err}, 32'd1);
    send(2, 257, '1);
    chk("rejlen_err", {31'b0, err}, 32'd1);
    send(3, 0, '1);
    chk("len0_done", {28'b0, done, err, select_out, busy}, 32'd8);
    @(negedge clk);
    chk("len0_clear", {31'b0, done}, 32'd0);
    @(posedge clk);
    chk("rej_rises", rise[0] + rise[1] + rise[2] + rise[3] + rise[4] +
        rise[5], 32'd0);

    clr();
    send(3, 32, 256'hAAAA_AAAA);
    k = 0;
    while (!(m_act && m_t == 63) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("rst_high", {26'b0, sclk}, 32'h08);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid", {28'b0, sclk == 0, select_out, cmd_ready, done}, 32'hA);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    chk("rst_rises", rise[3], 32'd11);

`ifdef GPIO_SERIAL_WRITER_ABORT_EN
    clr();
    send(5, 16, 256'hFFFF);
    k = 0;
    while (!(m_act && m_t == 19) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    abort_in = 1'b1;
    @(negedge clk);
    abort_in = 1'b0;
    chk("abort_pulse", {26'b0, done, err, select_out, busy, cmd_ready,
        sclk == 0}, 32'h33);
    @(negedge clk);
    chk("abort_clear", {30'b0, done, err}, 32'd0);
    @(posedge clk);
    chk("abort_rises", rise[5], 32'd3);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
